muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit for the RV64M/RV32M extension. Sits beside alu in EX.
//  Accepts one request via valid/ready, iterates one bit per cycle, then holds the result until consumed.
//  Covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the *W forms. Supports flush.
// PARAMETERS
//  XLEN        64  operand/result width; 32 or 64 (W ops only legal when XLEN==64)
//  W_SUPPORT   1   1: honour op_w_i; 0: op_w_i ignored, treated as 0
// PORTS
//  clk_i          in   1            clock
//  rst_i          in   1            synchronous reset, active-high
//  flush_i        in   1            kill in-flight/pending op (pipeline redirect)
//  req_valid_i    in   1            request present
//  req_ready_o    out  1            unit can accept (state IDLE)
//  md_info_i      in   MD_INFO_WIDTH  one-hot op select (MD_MUL..MD_REMU)
//  op_w_i         in   1            32-bit W variant
//  rs1_rdata_i    in   XLEN         operand a / dividend
//  rs2_rdata_i    in   XLEN         operand b / divisor
//  resp_valid_o   out  1            result valid
//  resp_ready_i   in   1            consumer takes result
//  md_res_o       out  XLEN         result (W ops: 32-bit result sign-extended)
//  busy_o         out  1            state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, req_ready_o=1, resp_valid_o=0, md_res_o=0, busy_o=0, counter=0.
//  - Accept on req_valid_i & req_ready_o & ~flush_i; operands, op and W flag latched at that edge.
//  - FSM: IDLE -> CALC (normal) | DONE (div special case); CALC -> DONE when counter hits N-1;
//    DONE -> IDLE on resp_ready_i. flush_i in any state -> IDLE next cycle, resp_valid_o=0.
//  - N = 32 if op_w else XLEN. Handshake edge = cycle 0; resp_valid_o high from cycle N+1
//    (div special cases: cycle 1). md_res_o stable while resp_valid_o & ~resp_ready_i.
//  - req_ready_o=0 in CALC/DONE: no new request accepted same cycle as a response handshake.
//  - Datapath: operands converted to magnitudes per op signedness (MULHSU: a signed, b unsigned;
//    W ops: low 32 bits, sign/zero-extended per op); unsigned shift-add multiply (2N-bit product)
//    or restoring divide; sign fix applied on CALC->DONE transition, result registered.
//  - Result select: MUL low N bits; MULH* high N bits; DIV*/REM* quotient/remainder.
//  - Divide by zero: quotient = all ones, remainder = dividend (N-bit, then W-extend).
//  - Signed overflow (dividend=most-negative, divisor=-1, DIV/REM/DIVW/REMW):
//    quotient = dividend, remainder = 0.
//  - Remainder sign = dividend sign; quotient negated iff operand signs differ (signed ops only).
//  - W ops: final 32-bit result sign-extended to XLEN, including DIVUW/REMUW.
//  - flush_i with req_valid_i in same cycle: request dropped, req_ready_o stays 1.
//  - rst_i mid-operation: identical to reset; no response emitted.
// STRUCTURE
//  - defines.v gains MD_INFO_WIDTH and bit indices MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
//    MD_DIV, MD_DIVU, MD_REM, MD_REMU; FSM state encodings as localparams in the module.
//  - One sub-module: md_iter_core (shared 2N-bit shift register + N+1-bit adder/subtractor,
//    one iteration per cycle, mode = mul|div); FSM, sign handling, special cases in muldiv_unit.
// TESTING
//  - MUL 7 * -3 (XLEN=64) -> md_res_o=0xFFFF_FFFF_FFFF_FFEB, resp_valid_o at cycle 65.
//  - MULHU 0xFFFF_FFFF_FFFF_FFFF * same -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU -1 * 2 -> all ones.
//  - DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> all ones; DIVW 0x1_8000_0000/1
//    -> 0xFFFF_FFFF_8000_0000 at cycle 33.
//  - DIVU 5/0 -> all ones, REMU 5/0 -> 5, DIV 0x8000_0000_0000_0000/-1 -> same value,
//    REM -> 0; all at cycle 1.
//  - resp_ready_i low 10 cycles after resp_valid_o -> result held, req_ready_o=0;
//    pulse resp_ready_i -> IDLE next cycle.
//  - flush_i at cycle 20 of a DIV -> resp_valid_o never rises, req_ready_o=1 next cycle;
//    back-to-back MUL then gives correct result.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op-select bit positions,
// FSM state type and the decoded-op record.
package muldiv_unit_pkg;

  localparam int MD_INFO_WIDTH = 8;

  localparam int MD_MUL    = 0;
  localparam int MD_MULH   = 1;
  localparam int MD_MULHSU = 2;
  localparam int MD_MULHU  = 3;
  localparam int MD_DIV    = 4;
  localparam int MD_DIVU   = 5;
  localparam int MD_REM    = 6;
  localparam int MD_REMU   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic is_div;    // divide family (quotient or remainder)
    logic is_rem;    // remainder wanted instead of quotient
    logic is_hi;     // upper half of the product wanted
    logic a_signed;  // operand a taken as two's complement
    logic b_signed;  // operand b taken as two's complement
  } md_op_t;

  // A malformed select with the MUL bit set falls back to plain MUL.
  function automatic md_op_t md_decode(input logic [MD_INFO_WIDTH-1:0] info);
    md_op_t op;
    op.is_div   = (info[MD_DIV] | info[MD_DIVU] | info[MD_REM] | info[MD_REMU]) & ~info[MD_MUL];
    op.is_rem   = (info[MD_REM] | info[MD_REMU]) & ~info[MD_MUL];
    op.is_hi    = (info[MD_MULH] | info[MD_MULHSU] | info[MD_MULHU]) & ~info[MD_MUL];
    op.a_signed = (info[MD_MULH] | info[MD_MULHSU] | info[MD_DIV] | info[MD_REM]) & ~info[MD_MUL];
    op.b_signed = (info[MD_MULH] | info[MD_DIV] | info[MD_REM]) & ~info[MD_MUL];
    return op;
  endfunction

endpackage

// File: rtl/muldiv_unit_core.sv
// Iterative unsigned core shared by multiply and divide: a 2*XLEN-bit
// accumulator/shift register and a single XLEN+1-bit adder/subtractor,
// advancing one bit per step.
//   mul: acc = {hi, lo}, lo starts as the multiplier; add multiplicand to hi
//        when lo[0] is set, then shift right. After N steps the 2N-bit
//        product sits at acc >> (XLEN-N).
//   div: restoring divide; lo starts as the dividend left-aligned to N bits.
//        After N steps the quotient is in lo, the remainder in hi.
module md_iter_core
  #(parameter int XLEN = 64)
  (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              div_mode_i,
    input  logic              w_i,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    output logic [2*XLEN-1:0] acc_nxt_o
  );

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              div_q;

  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN:0]     rem_ext;
  logic [XLEN:0]     add_x;
  logic [XLEN:0]     add_y;
  logic              add_cin;
  logic [XLEN:0]     sum;
  logic              quo_bit;
  logic [XLEN-1:0]   new_rem;

  // One iteration of shift-add or restoring subtract through the shared adder.
  always_comb begin
    acc_hi  = acc_q[2*XLEN-1:XLEN];
    acc_lo  = acc_q[XLEN-1:0];
    rem_ext = {acc_hi, acc_lo[XLEN-1]};
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (div_q) begin
      add_x   = rem_ext;
      add_y   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_hi};
      add_y   = acc_lo[0] ? {1'b0, opnd_q} : '0;
    end
    sum     = add_x + add_y + (XLEN+1)'(add_cin);
    quo_bit = ~sum[XLEN];
    new_rem = quo_bit ? sum[XLEN-1:0] : rem_ext[XLEN-1:0];
    if (div_q) begin
      acc_nxt_o = {new_rem, acc_lo[XLEN-2:0], quo_bit};
    end else begin
      acc_nxt_o = {sum, acc_lo[XLEN-1:1]};
    end
  end

  // Load operands on accept, then advance once per step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      div_q <= div_mode_i;
      if (div_mode_i) begin
        acc_q  <= {{XLEN{1'b0}}, (w_i ? (op_a_i << (XLEN-32)) : op_a_i)};
        opnd_q <= op_b_i;
      end else begin
        acc_q  <= {{XLEN{1'b0}}, op_b_i};
        opnd_q <= op_a_i;
      end
    end else if (step_i) begin
      acc_q <= acc_nxt_o;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit (RV64M/RV32M incl. W forms).
// Operands are reduced to magnitudes on accept, iterated one bit per cycle
// in md_iter_core, sign-fixed on the final step and held until consumed.
// Divide-by-zero and signed overflow bypass the iteration entirely.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request
//   CALC    | iterating, counter 0..N-1
//   DONE    | result registered, resp_valid_o high until resp_ready_i
module muldiv_unit
  import muldiv_unit_pkg::*;
  #(
    parameter int XLEN      = 64,
    parameter int W_SUPPORT = 1
  )
  (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [MD_INFO_WIDTH-1:0] md_info_i,
    input  logic                     op_w_i,
    input  logic [XLEN-1:0]          rs1_rdata_i,
    input  logic [XLEN-1:0]          rs2_rdata_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [XLEN-1:0]          md_res_o,
    output logic                     busy_o
  );

  localparam bit          W_OK  = (W_SUPPORT != 0) && (XLEN == 64);
  localparam int          CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = ~XLEN'(32'h7FFF_FFFF);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  md_state_e         state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              last;

  md_op_t            op_dec;
  logic              w_in;
  logic              accept;
  logic              sa_in, sb_in;
  logic [XLEN-1:0]   a_ext, b_ext;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   spec_raw, spec_res;

  logic              rem_q, hi_q, w_q, sa_q, sb_q, div_q;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   quo, rem, calc_raw, calc_res;
  logic [XLEN-1:0]   md_res_q;

  // Request-side decode: operand views, magnitudes and the bypass cases.
  always_comb begin
    op_dec   = md_decode(md_info_i);
    w_in     = W_OK && op_w_i;
    accept   = req_valid_i && (state_q == ST_IDLE) && !flush_i;
    if (w_in) begin
      a_ext = op_dec.a_signed ? sext32(rs1_rdata_i[31:0]) : XLEN'(rs1_rdata_i[31:0]);
      b_ext = op_dec.b_signed ? sext32(rs2_rdata_i[31:0]) : XLEN'(rs2_rdata_i[31:0]);
    end else begin
      a_ext = rs1_rdata_i;
      b_ext = rs2_rdata_i;
    end
    sa_in    = op_dec.a_signed && a_ext[XLEN-1];
    sb_in    = op_dec.b_signed && b_ext[XLEN-1];
    mag_a    = sa_in ? -a_ext : a_ext;
    mag_b    = sb_in ? -b_ext : b_ext;
    div_zero = op_dec.is_div && (b_ext == '0);
    div_ovf  = op_dec.is_div && op_dec.a_signed && (b_ext == '1) &&
               (a_ext == (w_in ? MIN_W : MIN_X));
    special  = div_zero || div_ovf;
    if (op_dec.is_rem) begin
      spec_raw = div_zero ? rs1_rdata_i : '0;
    end else begin
      spec_raw = div_zero ? '1 : rs1_rdata_i;
    end
    spec_res = w_in ? sext32(spec_raw[31:0]) : spec_raw;
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept && !special),
    .step_i     (state_q == ST_CALC),
    .div_mode_i (op_dec.is_div),
    .w_i        (w_in),
    .op_a_i     (mag_a),
    .op_b_i     (mag_b),
    .acc_nxt_o  (acc_nxt)
  );

  // Final-step result: sign fix and half/quotient/remainder select.
  always_comb begin
    prod_mag = w_q ? (acc_nxt >> (XLEN-32)) : acc_nxt;
    prod     = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
    quo      = (sa_q ^ sb_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem      = sa_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (div_q) begin
      calc_raw = rem_q ? rem : quo;
    end else if (hi_q) begin
      calc_raw = XLEN'(prod >> (w_q ? 32 : XLEN));
    end else begin
      calc_raw = XLEN'(prod);
    end
    calc_res = w_q ? sext32(calc_raw[31:0]) : calc_raw;
    last     = (cnt_q == (w_q ? CNT_W'(31) : CNT_W'(XLEN-1)));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt    = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (accept) state_nxt = special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (flush_i)   state_nxt = ST_IDLE;
        else if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        resp_valid_o = 1'b1;
        if (flush_i || resp_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  // Iteration counter: runs only while staying in CALC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if ((state_q == ST_CALC) && (state_nxt == ST_CALC)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Op attributes latched on accept; result registered on entry to DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
      hi_q     <= 1'b0;
      w_q      <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      md_res_q <= '0;
    end else begin
      if (accept) begin
        div_q <= op_dec.is_div;
        rem_q <= op_dec.is_rem;
        hi_q  <= op_dec.is_hi;
        w_q   <= w_in;
        sa_q  <= sa_in;
        sb_q  <= sb_in;
      end
      if (accept && special) begin
        md_res_q <= spec_res;
      end else if ((state_q == ST_CALC) && last && !flush_i) begin
        md_res_q <= calc_res;
      end
    end
  end

  assign md_res_o = md_res_q;

endmodule
